// File: rtl/stepper_seq_gen_if.sv
// Move-command bus of stepper_seq_gen: valid/ready handshake carrying
// target channel, direction and step count.
interface stepper_seq_gen_if #(
  parameter int N_CH    = 2,
  parameter int STEPS_W = 16
);
  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic               cmd_valid;
  logic               cmd_ready;
  logic [CH_W-1:0]    cmd_ch;
  logic               cmd_dir;
  logic [STEPS_W-1:0] cmd_steps;

  modport master (
    output cmd_valid, cmd_ch, cmd_dir, cmd_steps,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_ch, cmd_dir, cmd_steps,
    output cmd_ready
  );
endinterface

// File: rtl/stepper_seq_gen.sv
// stepper_seq_gen: multi-channel stepper-motor sequence generator.
// A shared step timer paces all channels; each channel runs wave, half-step
// or two-phase sequences over an 8-entry phase table and drives the bridge
// pins through registers. A shared 4-bit counter produces vref PWM.
// Optional feature: define STEPPER_HOLD_EN to keep idle channels energised
// on their last coil pattern (holding torque).
module stepper_seq_gen #(
  parameter int N_CH     = 2,
  parameter int PERIOD_W = 24,
  parameter int STEPS_W  = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  stepper_seq_gen_if.slave    cmd,
  input  logic [PERIOD_W-1:0] period_i,
  input  logic [2*N_CH-1:0]   mode_i,
  input  logic [4*N_CH-1:0]   vref_level_i,
  input  logic                stop_i,
  output logic [N_CH-1:0]     busy_o,
  output logic [N_CH-1:0]     done_o,
  output logic [N_CH-1:0]     ina1_o,
  output logic [N_CH-1:0]     ina2_o,
  output logic [N_CH-1:0]     inb1_o,
  output logic [N_CH-1:0]     inb2_o,
  output logic [N_CH-1:0]     stby_o,
  output logic [N_CH-1:0]     vref_pwm_o
);

`ifdef STEPPER_HOLD_EN
  localparam logic HOLD_EN = 1'b1;
`else
  localparam logic HOLD_EN = 1'b0;
`endif

  // Phase table: {ina1, ina2, inb1, inb2} for each phase index.
  function automatic logic [3:0] phase_pins(input logic [2:0] idx);
    logic [3:0] p;
    case (idx)
      3'd0:    p = 4'b1000; // A+
      3'd1:    p = 4'b1010; // A+ B+
      3'd2:    p = 4'b0010; // B+
      3'd3:    p = 4'b0110; // A- B+
      3'd4:    p = 4'b0100; // A-
      3'd5:    p = 4'b0101; // A- B-
      3'd6:    p = 4'b0001; // B-
      3'd7:    p = 4'b1001; // A+ B-
      default: p = 4'b0000;
    endcase
    return p;
  endfunction

  // Index after one step; 3-bit arithmetic gives the modulo-8 wrap for free.
  function automatic logic [2:0] next_idx(input logic [2:0] idx,
                                          input logic [1:0] md,
                                          input logic       dir);
    logic [2:0] n;
    case (md)
      2'd0: begin
        n    = dir ? (idx + 3'd2) : (idx - 3'd2);
        n[0] = 1'b0;
      end
      2'd1: n = dir ? (idx + 3'd1) : (idx - 3'd1);
      2'd2: begin
        n    = dir ? (idx + 3'd2) : (idx - 3'd2);
        n[0] = 1'b1;
      end
      default: n = idx; // coils off: index frozen, steps still counted
    endcase
    return n;
  endfunction

  logic [PERIOD_W-1:0] tmr_q, tmr_d;
  logic                tick_s;
  logic [3:0]          pwm_cnt_q, pwm_cnt_d;

  logic [N_CH-1:0]     busy_q, busy_d, dir_q, dir_d, done_q, done_d, fin_s;
  logic [2:0]          idx_q   [N_CH];
  logic [2:0]          idx_d   [N_CH];
  logic [STEPS_W-1:0]  steps_q [N_CH];
  logic [STEPS_W-1:0]  steps_d [N_CH];
  logic [3:0]          pat_s   [N_CH];

  logic [N_CH-1:0]     ina1_q, ina2_q, inb1_q, inb2_q, stby_q, pwm_q;
  logic [N_CH-1:0]     ina1_d, ina2_d, inb1_d, inb2_d, stby_d, pwm_d;

  logic [31:0]         ch_ext_s;
  logic                ch_ok_s, sel_busy_s, accept_s;

  // Down-counting step timer; the period is sampled only at reload.
  always_comb begin
    tick_s    = (tmr_q == {PERIOD_W{1'b0}});
    pwm_cnt_d = pwm_cnt_q + 4'd1;
    if (tick_s) begin
      if (period_i == {PERIOD_W{1'b0}}) begin
        tmr_d = {PERIOD_W{1'b0}};
      end else begin
        tmr_d = period_i - PERIOD_W'(1);
      end
    end else begin
      tmr_d = tmr_q - PERIOD_W'(1);
    end
  end

  // Command readiness: target channel exists, is idle, and no stop pending.
  always_comb begin
    ch_ext_s   = 32'(cmd.cmd_ch);
    ch_ok_s    = (ch_ext_s < 32'(N_CH));
    sel_busy_s = 1'b0;
    for (int c = 0; c < N_CH; c++) begin
      if (ch_ext_s == 32'(c)) begin
        sel_busy_s = busy_q[c];
      end else begin
        sel_busy_s = sel_busy_s;
      end
    end
    accept_s = cmd.cmd_valid && cmd.cmd_ready;
  end

  assign cmd.cmd_ready = ch_ok_s && !sel_busy_s && !stop_i;

  // Per-channel move control: stop, stepping on tick, command accept.
  always_comb begin
    busy_d  = busy_q;
    dir_d   = dir_q;
    done_d  = {N_CH{1'b0}};
    fin_s   = {N_CH{1'b0}};
    idx_d   = idx_q;
    steps_d = steps_q;
    for (int c = 0; c < N_CH; c++) begin
      if (stop_i) begin
        busy_d[c] = 1'b0;
      end else if (busy_q[c]) begin
        if (tick_s) begin
          idx_d[c]   = next_idx(idx_q[c], mode_i[2*c +: 2], dir_q[c]);
          steps_d[c] = steps_q[c] - STEPS_W'(1);
          if (steps_q[c] == STEPS_W'(1)) begin
            busy_d[c] = 1'b0;
            done_d[c] = 1'b1;
            fin_s[c]  = 1'b1;
          end else begin
            busy_d[c] = 1'b1;
          end
        end else begin
          busy_d[c] = 1'b1;
        end
      end else if (accept_s && (ch_ext_s == 32'(c))) begin
        if (cmd.cmd_steps != {STEPS_W{1'b0}}) begin
          busy_d[c]  = 1'b1;
          dir_d[c]   = cmd.cmd_dir;
          steps_d[c] = cmd.cmd_steps;
        end else begin
          done_d[c]  = 1'b1;
        end
      end else begin
        busy_d[c] = 1'b0;
      end
    end
  end

  // Pin decode from the next-state index, so coils follow the tick by one
  // edge; the final step stays visible for the cycle its done pulses.
  always_comb begin
    ina1_d = {N_CH{1'b0}};
    ina2_d = {N_CH{1'b0}};
    inb1_d = {N_CH{1'b0}};
    inb2_d = {N_CH{1'b0}};
    stby_d = {N_CH{1'b0}};
    pwm_d  = {N_CH{1'b0}};
    for (int c = 0; c < N_CH; c++) begin
      pat_s[c] = phase_pins(idx_d[c]);
      if ((busy_d[c] || fin_s[c] || HOLD_EN) && (mode_i[2*c +: 2] != 2'd3)) begin
        ina1_d[c] = pat_s[c][3];
        ina2_d[c] = pat_s[c][2];
        inb1_d[c] = pat_s[c][1];
        inb2_d[c] = pat_s[c][0];
        stby_d[c] = 1'b1;
      end else begin
        ina1_d[c] = 1'b0;
        ina2_d[c] = 1'b0;
        inb1_d[c] = 1'b0;
        inb2_d[c] = 1'b0;
        stby_d[c] = 1'b0;
      end
      pwm_d[c] = (pwm_cnt_q < vref_level_i[4*c +: 4]);
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmr_q     <= {PERIOD_W{1'b0}};
      pwm_cnt_q <= 4'd0;
      busy_q    <= {N_CH{1'b0}};
      dir_q     <= {N_CH{1'b0}};
      done_q    <= {N_CH{1'b0}};
      ina1_q    <= {N_CH{1'b0}};
      ina2_q    <= {N_CH{1'b0}};
      inb1_q    <= {N_CH{1'b0}};
      inb2_q    <= {N_CH{1'b0}};
      stby_q    <= {N_CH{1'b0}};
      pwm_q     <= {N_CH{1'b0}};
      for (int c = 0; c < N_CH; c++) begin
        idx_q[c]   <= 3'd0;
        steps_q[c] <= {STEPS_W{1'b0}};
      end
    end else begin
      tmr_q     <= tmr_d;
      pwm_cnt_q <= pwm_cnt_d;
      busy_q    <= busy_d;
      dir_q     <= dir_d;
      done_q    <= done_d;
      ina1_q    <= ina1_d;
      ina2_q    <= ina2_d;
      inb1_q    <= inb1_d;
      inb2_q    <= inb2_d;
      stby_q    <= stby_d;
      pwm_q     <= pwm_d;
      for (int c = 0; c < N_CH; c++) begin
        idx_q[c]   <= idx_d[c];
        steps_q[c] <= steps_d[c];
      end
    end
  end

  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign ina1_o     = ina1_q;
  assign ina2_o     = ina2_q;
  assign inb1_o     = inb1_q;
  assign inb2_o     = inb2_q;
  assign stby_o     = stby_q;
  assign vref_pwm_o = pwm_q;

endmodule

// File: tb/tb_stepper_seq_gen.sv
// Directed bench for stepper_seq_gen: table of moves on channel 0 plus
// hand-written sequences for dual-channel, stop, zero-step, coils-off,
// PWM duty and asynchronous reset. Honours STEPPER_HOLD_EN for idle checks.
module tb_stepper_seq_gen;
  localparam int N_CH     = 2;
  localparam int PERIOD_W = 24;
  localparam int STEPS_W  = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  stepper_seq_gen_if #(.N_CH(N_CH), .STEPS_W(STEPS_W)) cmd_if ();

  logic [PERIOD_W-1:0] period;
  logic [2*N_CH-1:0]   mode;
  logic [4*N_CH-1:0]   vref;
  logic                stop;
  logic [N_CH-1:0]     busy, done, ina1, ina2, inb1, inb2, stby, pwm;

  stepper_seq_gen #(.N_CH(N_CH), .PERIOD_W(PERIOD_W), .STEPS_W(STEPS_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cmd          (cmd_if),
    .period_i     (period),
    .mode_i       (mode),
    .vref_level_i (vref),
    .stop_i       (stop),
    .busy_o       (busy),
    .done_o       (done),
    .ina1_o       (ina1),
    .ina2_o       (ina2),
    .inb1_o       (inb1),
    .inb2_o       (inb2),
    .stby_o       (stby),
    .vref_pwm_o   (pwm)
  );

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [1:0]       md;
    logic             dir;
    logic [7:0]       steps;
    logic [0:9][2:0]  exp;
  } vec_t;

  vec_t vec [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Expected pins {ina1,ina2,inb1,inb2} per phase index, from the phase list.
  function automatic logic [3:0] ref_pins(input logic [2:0] i);
    case (i)
      3'd0: return 4'b1000;
      3'd1: return 4'b1010;
      3'd2: return 4'b0010;
      3'd3: return 4'b0110;
      3'd4: return 4'b0100;
      3'd5: return 4'b0101;
      3'd6: return 4'b0001;
      default: return 4'b1001;
    endcase
  endfunction

  function automatic logic [3:0] pins_of(input int c);
    return {ina1[c], ina2[c], inb1[c], inb2[c]};
  endfunction

  // Present a command at the current negedge; returns at the next negedge.
  task automatic issue(input int ch, input logic dr, input int st, input logic exp_rdy, input string tag);
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_ch    = ch[0];
    cmd_if.cmd_dir   = dr;
    cmd_if.cmd_steps = 16'(st);
    #1;
    check(tag, 32'(cmd_if.cmd_ready), 32'(exp_rdy));
    @(negedge clk);
    cmd_if.cmd_valid = 1'b0;
  endtask

  // Run one move on a channel and compare each new coil pattern in order.
  task automatic run_move(input int ch, input logic [1:0] md, input logic dr, input int st,
                          input logic [2:0] start, input logic [0:9][2:0] ex, input string tag);
    logic [3:0] last;
    logic [3:0] got [10];
    int nchg, bcyc, sbad, cyc;
    bit fin;
    mode[2*ch +: 2] = md;
    issue(ch, dr, st, 1'b1, {tag, "_rdy"});
    last = ref_pins(start);
    nchg = 0; bcyc = 0; sbad = 0; cyc = 0; fin = 1'b0;
    while (!fin && cyc < 200) begin
      if (busy[ch]) begin
        bcyc++;
        if (stby[ch] !== 1'b1) sbad++;
      end
      if ((busy[ch] || done[ch]) && pins_of(ch) != last) begin
        if (nchg < 10) got[nchg] = pins_of(ch);
        nchg++;
        last = pins_of(ch);
      end
      if (done[ch]) begin
        fin = 1'b1;
      end else begin
        @(negedge clk);
        cyc++;
      end
    end
    check({tag, "_done_seen"}, 32'(fin), 32'd1);
    check({tag, "_busy_at_done"}, 32'(busy[ch]), 32'd0);
    check({tag, "_nsteps"}, 32'(nchg), 32'(st));
    for (int k = 0; k < st && k < 10 && k < nchg; k++)
      check($sformatf("%s_pat%0d", tag, k), 32'(got[k]), 32'(ref_pins(ex[k])));
    check({tag, "_busy_len"}, 32'((bcyc >= 4*(st-1)+1) && (bcyc <= 4*st)), 32'd1);
    check({tag, "_stby"}, 32'(sbad), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    logic [2:0] cur0;
    logic [3:0] last0, last1;
    int n0, n1, d0c, d1c, sbad, bcyc, cnt0, cnt1, cyc;
    bit f0, f1, fin;

    vec[0] = '{md:2'd1, dir:1'b1, steps:8'd10, exp:{3'd1,3'd2,3'd3,3'd4,3'd5,3'd6,3'd7,3'd0,3'd1,3'd2}};
    vec[1] = '{md:2'd1, dir:1'b0, steps:8'd1,  exp:{3'd1,3'd0,3'd0,3'd0,3'd0,3'd0,3'd0,3'd0,3'd0,3'd0}};
    vec[2] = '{md:2'd0, dir:1'b0, steps:8'd3,  exp:{3'd6,3'd4,3'd2,3'd0,3'd0,3'd0,3'd0,3'd0,3'd0,3'd0}};
    vec[3] = '{md:2'd2, dir:1'b1, steps:8'd2,  exp:{3'd5,3'd7,3'd0,3'd0,3'd0,3'd0,3'd0,3'd0,3'd0,3'd0}};
    vec[4] = '{md:2'd1, dir:1'b1, steps:8'd2,  exp:{3'd0,3'd1,3'd0,3'd0,3'd0,3'd0,3'd0,3'd0,3'd0,3'd0}};
    vec[5] = '{md:2'd1, dir:1'b0, steps:8'd2,  exp:{3'd0,3'd7,3'd0,3'd0,3'd0,3'd0,3'd0,3'd0,3'd0,3'd0}};
    vec[6] = '{md:2'd2, dir:1'b0, steps:8'd1,  exp:{3'd5,3'd0,3'd0,3'd0,3'd0,3'd0,3'd0,3'd0,3'd0,3'd0}};
    vec[7] = '{md:2'd0, dir:1'b1, steps:8'd2,  exp:{3'd6,3'd0,3'd0,3'd0,3'd0,3'd0,3'd0,3'd0,3'd0,3'd0}};

    period = 24'd4;
    mode   = {2'd1, 2'd1};
    vref   = {4'd8, 4'd0};
    stop   = 1'b0;
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_ch    = 1'b0;
    cmd_if.cmd_dir   = 1'b0;
    cmd_if.cmd_steps = 16'd0;

    // Reset state
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", 32'({busy, done, ina1, ina2, inb1, inb2, stby, pwm}), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
`ifdef STEPPER_HOLD_EN
    check("idle_hold_pins", 32'(pins_of(0)), 32'(ref_pins(3'd0)));
    check("idle_hold_stby", 32'(stby), 32'h3);
`else
    check("idle_pins", 32'({ina1, ina2, inb1, inb2}), 32'd0);
    check("idle_stby", 32'(stby), 32'd0);
`endif

    // Table of moves on channel 0
    cur0 = 3'd0;
    for (int e = 0; e < 8; e++) begin
      run_move(0, vec[e].md, vec[e].dir, int'(vec[e].steps), cur0, vec[e].exp, $sformatf("mv%0d", e));
      cur0 = vec[e].exp[int'(vec[e].steps) - 1];
    end

    // Busy channel refuses, other channel accepts; both step on the same ticks
    mode = {2'd1, 2'd1};
    issue(0, 1'b1, 4, 1'b1, "dual_rdy_ch0");
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_ch    = 1'b0;
    cmd_if.cmd_steps = 16'd7;
    #1;
    check("dual_rdy_busy", 32'(cmd_if.cmd_ready), 32'd0);
    @(negedge clk);
    cmd_if.cmd_valid = 1'b0;
    issue(1, 1'b1, 4, 1'b1, "dual_rdy_ch1");
    last0 = ref_pins(cur0); last1 = ref_pins(3'd0);
    n0 = 0; n1 = 0; sbad = 0; f0 = 1'b0; f1 = 1'b0; cyc = 0; d0c = -1; d1c = -1;
    while (!(f0 && f1) && cyc < 60) begin
      if ((busy[0] || done[0]) && pins_of(0) != last0) begin n0++; last0 = pins_of(0); cnt0 = 1; end
      else cnt0 = 0;
      if ((busy[1] || done[1]) && pins_of(1) != last1) begin n1++; last1 = pins_of(1); cnt1 = 1; end
      else cnt1 = 0;
      if (cnt0 != cnt1) sbad++;
      if (done[0]) begin f0 = 1'b1; d0c = cyc; end
      if (done[1]) begin f1 = 1'b1; d1c = cyc; end
      if (!(f0 && f1)) begin @(negedge clk); cyc++; end
    end
    check("dual_sync", 32'(sbad), 32'd0);
    check("dual_n0", 32'(n0), 32'd4);
    check("dual_n1", 32'(n1), 32'd4);
    check("dual_done_same", 32'(d0c == d1c && d0c >= 0), 32'd1);
    check("dual_final1", 32'(pins_of(1)), 32'(ref_pins(3'd4)));
    cur0 = 3'd4;
    @(negedge clk);
    check("dual_no_rearm", 32'({busy, done}), 32'd0);

    // Stop at step 5 of 10
    issue(0, 1'b1, 10, 1'b1, "stop_rdy");
    last0 = ref_pins(cur0); n0 = 0; cyc = 0;
    while (n0 < 5 && cyc < 60) begin
      if (busy[0] && pins_of(0) != last0) begin n0++; last0 = pins_of(0); end
      if (n0 < 5) begin @(negedge clk); cyc++; end
    end
    check("stop_reach5", 32'(n0), 32'd5);
    stop = 1'b1;
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_ch    = 1'b1;
    cmd_if.cmd_steps = 16'd3;
    #1;
    check("stop_blocks_ready", 32'(cmd_if.cmd_ready), 32'd0);
    @(negedge clk);
    stop = 1'b0;
    cmd_if.cmd_valid = 1'b0;
    check("stop_busy_clear", 32'(busy), 32'd0);
    cnt0 = 0;
    for (int i = 0; i < 12; i++) begin
      if (done != 2'b00 || busy != 2'b00) cnt0++;
      @(negedge clk);
    end
    check("stop_no_done", 32'(cnt0), 32'd0);
    cur0 = cur0 + 3'd5;
`ifdef STEPPER_HOLD_EN
    check("stop_hold_pins", 32'(pins_of(0)), 32'(ref_pins(cur0)));
`else
    check("stop_idle_pins", 32'(pins_of(0)), 32'd0);
`endif
    run_move(0, 2'd1, 1'b1, 1, cur0, {cur0 + 3'd1, 27'd0}, "stop_held");
    cur0 = cur0 + 3'd1;

    // Zero-step command
    @(negedge clk);
    issue(0, 1'b1, 0, 1'b1, "zero_rdy");
    check("zero_done", 32'({busy[0], done[0]}), 32'b01);
    @(negedge clk);
    check("zero_after", 32'({busy[0], done[0]}), 32'b00);

    // Coils-off mode counts steps without moving the index
    mode[1:0] = 2'd3;
    issue(0, 1'b1, 3, 1'b1, "off_rdy");
    sbad = 0; bcyc = 0; fin = 1'b0; cyc = 0;
    while (!fin && cyc < 40) begin
      if (busy[0]) begin
        bcyc++;
        if (pins_of(0) != 4'b0000 || stby[0] != 1'b0) sbad++;
      end
      if (done[0]) fin = 1'b1;
      else begin @(negedge clk); cyc++; end
    end
    check("off_done", 32'(fin), 32'd1);
    check("off_pins", 32'(sbad), 32'd0);
    check("off_len", 32'(bcyc >= 9 && bcyc <= 12), 32'd1);
    run_move(0, 2'd1, 1'b1, 1, cur0, {cur0 + 3'd1, 27'd0}, "off_idx_kept");

    // PWM duty over a 16-cycle window
    vref = {4'd8, 4'd0};
    repeat (2) @(negedge clk);
    cnt0 = 0; cnt1 = 0;
    for (int i = 0; i < 16; i++) begin
      cnt0 += int'(pwm[0]); cnt1 += int'(pwm[1]);
      @(negedge clk);
    end
    check("pwm_lvl0", 32'(cnt0), 32'd0);
    check("pwm_lvl8", 32'(cnt1), 32'd8);
    vref = {4'd8, 4'd15};
    repeat (2) @(negedge clk);
    cnt0 = 0;
    for (int i = 0; i < 16; i++) begin
      cnt0 += int'(pwm[0]);
      @(negedge clk);
    end
    check("pwm_lvl15", 32'(cnt0), 32'd15);

    // Asynchronous reset mid-move
    issue(0, 1'b1, 10, 1'b1, "rst_rdy");
    repeat (6) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_outputs", 32'({busy, done, ina1, ina2, inb1, inb2, stby, pwm}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cnt0 = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (busy != 2'b00 || done != 2'b00) cnt0++;
    end
    check("rst_stays_idle", 32'(cnt0), 32'd0);
`ifdef STEPPER_HOLD_EN
    check("rst_hold_pins", 32'(pins_of(0)), 32'(ref_pins(3'd0)));
    check("rst_hold_stby", 32'(stby), 32'h3);
`else
    check("rst_idle_pins", 32'({ina1, ina2, inb1, inb2}), 32'd0);
    check("rst_idle_stby", 32'(stby), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
